bayer_window_5x5: RTL and testbench



---
 rtl/cfa_pkg.sv | 18 +
 rtl/line_buffer.sv | 25 ++
 rtl/bayer_window_5x5.sv | 208 ++++++++++++++++++++
 tb/tb_bayer_window_5x5.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// Shared CFA pipeline definitions: pixel type and 5x5 window geometry.
package cfa_pkg;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned WIN_N = 5;
  localparam int unsigned WIN_R = 2;

  localparam int OFF_M2 = -2;
  localparam int OFF_M1 = -1;
  localparam int OFF_P0 = 0;
  localparam int OFF_P1 = 1;
  localparam int OFF_P2 = 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [0:0] {StIdle, StRun} win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One-line pixel RAM: synchronous write, combinational read, so a same-address
// read in the write cycle returns the old word.
module line_buffer #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 640,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/bayer_window_5x5.sv
// Streaming 5x5 Bayer neighbourhood generator: four chained line buffers feed a
// 5x5 shift window; one start pulse per interior centre pixel.
module bayer_window_5x5 #(
  parameter int unsigned PIX_W = 12,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  localparam int unsigned ColW = $clog2(IMG_W),
  localparam int unsigned RowW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_start,
  output logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
  output logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
  output logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
  output logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
  output logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
  output logic [RowW-1:0]  out_row,
  output logic [ColW-1:0]  out_col,
  output logic [1:0]       out_phase,
  output logic             frame_done
);

  import cfa_pkg::*;

  localparam int unsigned NumLb = WIN_N - 1;

  win_state_e      state_q, state_d;
  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic            accept, last_pix;

  logic [PIX_W-1:0] lb_rd [NumLb];
  logic [PIX_W-1:0] lb_wr [NumLb];

  // Stage 1
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_win_q, s1_win_d;
  logic                         s1_last_q, s1_last_d;
  logic [RowW-1:0]              s1_row_q, s1_row_d;
  logic [ColW-1:0]              s1_col_q, s1_col_d;
  logic [WIN_N-1:0][PIX_W-1:0]  s1_column_q, s1_column_d;

  // Stage 2; win_q[row][col], index 0 is the m2 offset
  logic [WIN_N-1:0][WIN_N-1:0][PIX_W-1:0] win_q, win_d;
  logic            out_start_q, out_start_d;
  logic            frame_done_q, frame_done_d;
  logic [RowW-1:0] out_row_q, out_row_d;
  logic [ColW-1:0] out_col_q, out_col_d;
  logic [1:0]      out_phase_q, out_phase_d;

  // Raster position and frame FSM; SOF forces the current pixel to (0,0)
  always_comb begin
    accept   = in_valid && (in_sof || (state_q == StRun));
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    last_pix = (cur_row == RowW'(IMG_H - 1)) && (cur_col == ColW'(IMG_W - 1));
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (last_pix) begin
        state_d = StIdle;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = StRun;
        if (cur_col == ColW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = cur_row + RowW'(1);
        end else begin
          col_d = cur_col + ColW'(1);
          row_d = cur_row;
        end
      end
    end
  end

  for (genvar k = 0; k < NumLb; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = in_pix;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k-1];
    end

    line_buffer #(
      .Width (PIX_W),
      .Depth (IMG_W)
    ) u_line_buffer (
      .clk_i   (clk),
      .we_i    (accept),
      .addr_i  (cur_col),
      .wdata_i (lb_wr[k]),
      .rdata_o (lb_rd[k])
    );
  end

  always_comb begin
    s1_valid_d  = accept;
    s1_win_d    = accept && (cur_row >= RowW'(2 * WIN_R)) && (cur_col >= ColW'(2 * WIN_R));
    s1_last_d   = accept && last_pix;
    s1_row_d    = s1_row_q;
    s1_col_d    = s1_col_q;
    s1_column_d = s1_column_q;
    if (accept) begin
      s1_row_d = cur_row;
      s1_col_d = cur_col;
      // Oldest line (LB3) at the top, live pixel at the bottom
      for (int r = 0; r < NumLb; r++) begin
        s1_column_d[r] = lb_rd[NumLb-1-r];
      end
      s1_column_d[WIN_N-1] = in_pix;
    end
  end

  always_comb begin
    win_d        = win_q;
    out_start_d  = s1_win_q;
    frame_done_d = s1_last_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    if (s1_valid_q) begin
      for (int r = 0; r < WIN_N; r++) begin
        for (int c = 0; c < WIN_N - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WIN_N-1] = s1_column_q[r];
      end
    end
    if (s1_win_q) begin
      out_row_d = s1_row_q - RowW'(WIN_R);
      out_col_d = s1_col_q - ColW'(WIN_R);
    end
    out_phase_d = {out_row_d[0], out_col_d[0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_win_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
      s1_column_q  <= '0;
      win_q        <= '0;
      out_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_phase_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_win_q     <= s1_win_d;
      s1_last_q    <= s1_last_d;
      s1_row_q     <= s1_row_d;
      s1_col_q     <= s1_col_d;
      s1_column_q  <= s1_column_d;
      win_q        <= win_d;
      out_start_q  <= out_start_d;
      frame_done_q <= frame_done_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_phase_q  <= out_phase_d;
    end
  end

  assign out_start  = out_start_q;
  assign frame_done = frame_done_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_phase  = out_phase_q;

  assign p_m2_m2 = win_q[0][0];
  assign p_m2_m1 = win_q[0][1];
  assign p_m2_p0 = win_q[0][2];
  assign p_m2_p1 = win_q[0][3];
  assign p_m2_p2 = win_q[0][4];
  assign p_m1_m2 = win_q[1][0];
  assign p_m1_m1 = win_q[1][1];
  assign p_m1_p0 = win_q[1][2];
  assign p_m1_p1 = win_q[1][3];
  assign p_m1_p2 = win_q[1][4];
  assign p_p0_m2 = win_q[2][0];
  assign p_p0_m1 = win_q[2][1];
  assign p_p0_p0 = win_q[2][2];
  assign p_p0_p1 = win_q[2][3];
  assign p_p0_p2 = win_q[2][4];
  assign p_p1_m2 = win_q[3][0];
  assign p_p1_m1 = win_q[3][1];
  assign p_p1_p0 = win_q[3][2];
  assign p_p1_p1 = win_q[3][3];
  assign p_p1_p2 = win_q[3][4];
  assign p_p2_m2 = win_q[4][0];
  assign p_p2_m1 = win_q[4][1];
  assign p_p2_p0 = win_q[4][2];
  assign p_p2_p1 = win_q[4][3];
  assign p_p2_p2 = win_q[4][4];

endmodule

// File: tb/tb_bayer_window_5x5.sv
// Bench for bayer_window_5x5 on an 8x8 frame: an image-array model predicts every
// window, pulse and frame end two cycles after each accepted pixel.
module tb_bayer_window_5x5;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [11:0] in_pix = '0;
  logic        out_start, frame_done;
  logic [11:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2;
  logic [11:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2;
  logic [11:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2;
  logic [11:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2;
  logic [11:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2;
  logic [2:0]  out_row, out_col;
  logic [1:0]  out_phase;
  logic [24:0][11:0] dut_w;

  always #5 clk = ~clk;

  bayer_window_5x5 #(
    .PIX_W (12),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .out_start  (out_start),
    .p_m2_m2    (p_m2_m2), .p_m2_m1 (p_m2_m1), .p_m2_p0 (p_m2_p0), .p_m2_p1 (p_m2_p1),
    .p_m2_p2    (p_m2_p2),
    .p_m1_m2    (p_m1_m2), .p_m1_m1 (p_m1_m1), .p_m1_p0 (p_m1_p0), .p_m1_p1 (p_m1_p1),
    .p_m1_p2    (p_m1_p2),
    .p_p0_m2    (p_p0_m2), .p_p0_m1 (p_p0_m1), .p_p0_p0 (p_p0_p0), .p_p0_p1 (p_p0_p1),
    .p_p0_p2    (p_p0_p2),
    .p_p1_m2    (p_p1_m2), .p_p1_m1 (p_p1_m1), .p_p1_p0 (p_p1_p0), .p_p1_p1 (p_p1_p1),
    .p_p1_p2    (p_p1_p2),
    .p_p2_m2    (p_p2_m2), .p_p2_m1 (p_p2_m1), .p_p2_p0 (p_p2_p0), .p_p2_p1 (p_p2_p1),
    .p_p2_p2    (p_p2_p2),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_phase  (out_phase),
    .frame_done (frame_done)
  );

  // Element k = row*5 + col, row/col 0 meaning offset -2
  assign dut_w = {p_p2_p2, p_p2_p1, p_p2_p0, p_p2_m1, p_p2_m2,
                  p_p1_p2, p_p1_p1, p_p1_p0, p_p1_m1, p_p1_m2,
                  p_p0_p2, p_p0_p1, p_p0_p0, p_p0_m1, p_p0_m2,
                  p_m1_p2, p_m1_p1, p_m1_p0, p_m1_m1, p_m1_m2,
                  p_m2_p2, p_m2_p1, p_m2_p0, p_m2_m1, p_m2_m2};

  typedef struct packed {
    logic              start;
    logic              done;
    logic              shift;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [24:0][11:0] w;
  } ev_t;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int dones = 0;
  bit ramp_mode = 1'b0;
  bit have_win = 1'b0;
  bit m_run = 1'b0;
  int m_row = 0;
  int m_col = 0;
  logic [11:0]       img [H][W];
  logic [24:0][11:0] last_win = '0;
  ev_t               exp_ev = '0;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input ev_t e);
    chk("out_start", 300'(out_start), 300'(e.start));
    chk("frame_done", 300'(frame_done), 300'(e.done));
    if (e.start) begin
      chk("window", 300'(dut_w), 300'(e.w));
      chk("out_row", 300'(out_row), 300'(e.row));
      chk("out_col", 300'(out_col), 300'(e.col));
      chk("out_phase", 300'(out_phase), 300'({e.row[0], e.col[0]}));
      if (ramp_mode && pulses == 0) begin
        chk("first_m2m2", 300'(p_m2_m2), 300'(0));
        chk("first_p0p0", 300'(p_p0_p0), 300'(34));
        chk("first_p2p2", 300'(p_p2_p2), 300'(68));
        chk("first_rc", 300'({out_row, out_col}), 300'({3'd2, 3'd2}));
        chk("first_phase", 300'(out_phase), 300'(0));
      end
      if (ramp_mode && e.row == 2 && e.col == 3) chk("phase_2_3", 300'(out_phase), 300'(1));
      if (ramp_mode && e.row == 3 && e.col == 2) chk("phase_3_2", 300'(out_phase), 300'(2));
      if (ramp_mode && e.row == 3 && e.col == 3) chk("phase_3_3", 300'(out_phase), 300'(3));
      pulses++;
      last_win = e.w;
      have_win = 1'b1;
    end else if (e.shift) begin
      have_win = 1'b0;
    end else if (have_win) begin
      chk("window_hold", 300'(dut_w), 300'(last_win));
    end
    if (e.done) dones++;
  endtask

  // One clock: drive, let the edge accept, check what that edge exposed, then model it
  task automatic cycle(input bit v, input bit sof, input logic [11:0] pix);
    ev_t nev;
    in_valid = v;
    in_sof   = sof;
    in_pix   = pix;
    @(posedge clk);
    #1;
    check_outputs(exp_ev);
    nev = '0;
    if (v && sof) begin
      m_run = 1'b1;
      m_row = 0;
      m_col = 0;
    end
    if (v && m_run) begin
      img[m_row][m_col] = pix;
      nev.shift = 1'b1;
      if (m_row >= 4 && m_col >= 4) begin
        nev.start = 1'b1;
        nev.row   = 3'(m_row - 2);
        nev.col   = 3'(m_col - 2);
        for (int dr = 0; dr < 5; dr++)
          for (int dc = 0; dc < 5; dc++)
            nev.w[dr*5+dc] = img[m_row-4+dr][m_col-4+dc];
      end
      if (m_row == H - 1 && m_col == W - 1) begin
        nev.done = 1'b1;
        m_run = 1'b0;
        m_row = 0;
        m_col = 0;
      end else if (m_col == W - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    exp_ev = nev;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'($urandom));
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic run_frame(input bit ramp, input bit gaps, input int npix);
    int k;
    bit v;
    logic [11:0] pix;
    k = 0;
    while (k < npix) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        pix = ramp ? 12'((k / W) * 16 + (k % W)) : 12'($urandom);
        cycle(1'b1, k == 0, pix);
        k++;
      end else begin
        cycle(1'b0, 1'b0, 12'($urandom));
      end
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_row = 0;
    m_col = 0;
    exp_ev = '0;
    have_win = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, 300'(out_start), 300'(0));
    chk({tag, "_done"}, 300'(frame_done), 300'(0));
    chk({tag, "_window"}, 300'(dut_w), 300'(0));
    chk({tag, "_coords"}, 300'({out_row, out_col, out_phase}), 300'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Pixels before any SOF are ignored
    stray(12);

    // Continuous ramp frame, then stray pixels after the frame end
    ramp_mode = 1'b1;
    pulses = 0;
    dones = 0;
    run_frame(1'b1, 1'b0, W * H);
    stray(12);
    idle(3);
    chk("pulses_ramp", 300'(pulses), 300'((W - 4) * (H - 4)));
    chk("dones_ramp", 300'(dones), 300'(1));

    // Same ramp with random valid gaps
    pulses = 0;
    dones = 0;
    run_frame(1'b1, 1'b1, W * H);
    idle(3);
    chk("pulses_gaps", 300'(pulses), 300'(16));
    chk("dones_gaps", 300'(dones), 300'(1));

    // Random pixel frames with gaps
    ramp_mode = 1'b0;
    for (int f = 0; f < 2; f++) begin
      pulses = 0;
      dones = 0;
      run_frame(1'b0, 1'b1, W * H);
      idle(3);
      chk("pulses_rand", 300'(pulses), 300'(16));
      chk("dones_rand", 300'(dones), 300'(1));
    end

    // SOF reasserted at (5,3): 4 windows from the aborted frame plus 16 new ones
    ramp_mode = 1'b1;
    pulses = 0;
    dones = 0;
    run_frame(1'b1, 1'b0, 5 * W + 3);
    run_frame(1'b1, 1'b0, W * H);
    idle(3);
    chk("pulses_abort", 300'(pulses), 300'(20));
    chk("dones_abort", 300'(dones), 300'(1));

    // Asynchronous reset mid-frame
    run_frame(1'b0, 1'b0, 30);
    in_valid = 1'b0;
    in_sof = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    dones = 0;
    run_frame(1'b1, 1'b0, W * H);
    idle(3);
    chk("pulses_after_rst", 300'(pulses), 300'(16));
    chk("dones_after_rst", 300'(dones), 300'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
